// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NOR unit: one SLICE-wide gate slice reused
// over WIDTH/SLICE cycles, valid/ready on both sides.
module serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nx;
  logic [1:0]       op_q;
  logic             zero_q;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sr;
  logic             accept;
  logic             last;

  // Operands shift down so the active slice always sits at bit 0;
  // results shift in from the top and land in place after NSLICE steps.
  assign sa = a_q[SLICE-1:0];
  assign sb = b_q[SLICE-1:0];

  always_comb begin
    sr = '0;
    unique case (op_q)
      2'b00: sr = sa & sb;
      2'b01: sr = sa | sb;
      2'b10: sr = sa ^ sb;
      2'b11: sr = ~(sa | sb);
    endcase
  end

  generate
    if (NSLICE == 1) begin : g_one
      assign res_nx = sr;
      assign a_sh   = '0;
      assign b_sh   = '0;
    end else begin : g_multi
      assign res_nx = {sr, res_q[WIDTH-1:SLICE]};
      assign a_sh   = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
      assign b_sh   = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
    end
  endgenerate

  assign last   = (state == RUN) && (cnt == LAST);
  assign accept = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (in_valid && in_ready) state_nx = RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      a_q   <= a_sh;
      b_q   <= b_sh;
      res_q <= res_nx;
      if (last) zero_q <= (res_nx == '0);
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;
  assign zero      = zero_q && out_valid;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit: full-width reference model checked
// every cycle, plus directed vectors and a SLICE sweep.
module tb_serial_logic_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  logic        v1, rdy1, ov1, z1, busy1;
  logic [31:0] res1;
  logic        v32, rdy32, ov32, z32, busy32;
  logic [31:0] res32;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  serial_logic_unit dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  serial_logic_unit #(.WIDTH(32), .SLICE(1)) u_s1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v1), .in_ready(rdy1),
    .op(op), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .zero(z1), .busy(busy1)
  );

  serial_logic_unit #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v32), .in_ready(rdy32),
    .op(op), .a(a), .b(b),
    .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .zero(z32), .busy(busy32)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] f(input logic [1:0] o,
                                    input logic [31:0] x,
                                    input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Reference model: an op takes 8 cycles, then waits to be consumed.
  int          m_left;
  bit          m_run, m_val, m_acc;
  logic [31:0] m_pend, m_res, m_last;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run  = 0;
      m_val  = 0;
      m_left = 0;
      m_res  = 0;
      m_last = 0;
    end else begin
      m_acc = in_valid && !m_run && (!m_val || out_ready);
      if (m_val && out_ready) begin
        m_val  = 0;
        m_last = m_res;
      end
      if (m_run) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0;
          m_val = 1;
          m_res = m_pend;
        end
      end
      if (m_acc) begin
        m_pend = f(op, a, b);
        m_left = 8;
        m_run  = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_in_ready", in_ready,
          !m_run && (!m_val || out_ready));
      chk("m_out_valid", out_valid, m_val);
      chk("m_busy", busy, m_run || m_val);
      chk("m_zero", zero, m_val && (m_res == 0));
      if (m_val) chk("m_result", result, m_res);
      else if (!m_run) chk("m_result_hold", result, m_last);
    end
  end

  task automatic scramble();
    a  = $urandom;
    b  = $urandom;
    op = 2'($urandom);
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_lat"}, n, exp_lat);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r);
    int n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_rdy"}, in_ready, 1);
    in_valid = 1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 0;
    scramble();
    wait_valid(nm, 8);
    chk({nm, "_res"}, result, exp_r);
  endtask

  task automatic drain();
    out_ready = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit wide, input int exp_lat);
    int n = 0;
    a = 32'h0000FFFF;
    b = 32'h00FF00FF;
    op = 2'b11;
    if (wide) v32 = 1;
    else v1 = 1;
    @(posedge clk);
    #1;
    v1 = 0;
    v32 = 0;
    while (!(wide ? ov32 : ov1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(wide ? "s32_lat" : "s1_lat", n, exp_lat);
    chk(wide ? "s32_res" : "s1_res", wide ? res32 : res1, 32'hFF000000);
    chk(wide ? "s32_zero" : "s1_zero", wide ? z32 : z1, 0);
  endtask

  initial begin
    reset_n = 0;
    in_valid = 0;
    v1 = 0;
    v32 = 0;
    out_ready = 1;
    a = 0;
    b = 0;
    op = 0;
    chk_on = 1;
    #3;
    chk("rst_result", result, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("pin_nor", f(2'b11, 32'h0000FFFF, 32'h00FF00FF), 32'hFF000000);
    chk("pin_xor", f(2'b10, 32'hFFFFFFFF, 32'h12345678), 32'hEDCBA987);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;

    run_op("nor", 2'b11, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000);
    chk("nor_zero", zero, 0);

    run_op("and", 2'b00, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000);
    chk("and_zero", zero, 1);

    drain();
    out_ready = 0;
    run_op("xor", 2'b10, 32'hFFFFFFFF, 32'h12345678, 32'hEDCBA987);
    in_valid = 1;
    a = 32'h0000000F;
    b = 32'h000000F0;
    op = 2'b01;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 32'hEDCBA987);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("bp_take_busy", busy, 1);
    chk("bp_take_valid", out_valid, 0);
    wait_valid("bp_next", 8);
    chk("bp_next_res", result, 32'h000000FF);

    drain();
    out_ready = 0;
    run_op("or", 2'b01, 32'h80000001, 32'h00000002, 32'h80000003);
    in_valid = 1;
    a = 32'hFFFF0000;
    b = 32'h0F0F0F0F;
    op = 2'b00;
    out_ready = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    scramble();
    chk("b2b_valid", out_valid, 0);
    chk("b2b_busy", busy, 1);
    wait_valid("b2b", 8);
    chk("b2b_res", result, 32'h0F0F0000);

    drain();
    in_valid = 1;
    a = 32'h0000FFFF;
    b = 32'h00FF00FF;
    op = 2'b11;
    @(posedge clk);
    #1;
    in_valid = 0;
    scramble();
    repeat (4) @(posedge clk);
    #1;
    reset_n = 0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    chk("abort_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_valid", out_valid, 0);
    run_op("post", 2'b10, 32'hFFFFFFFF, 32'h12345678, 32'hEDCBA987);

    drain();
    sweep(0, 32);
    sweep(1, 1);
    repeat (3) @(posedge clk);
    #1;
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Time-multiplexed bitwise logic unit. Computes AND/OR/XOR/NOR on WIDTH-bit operands, SLICE bits per clock, so one narrow gate slice is reused across cycles instead of replicated WIDTH times.
- Serves as the area-reduced logic path for the multi-cycle execute option of the pipelined CPU.
- Valid/ready handshake on the operand side (consumer end) and on the result side (producer end).

Parameters:
WIDTH, 32, operand/result width in bits
SLICE, 4, bits processed per cycle; WIDTH must be an integer multiple of SLICE
NSLICE, WIDTH/SLICE, derived local constant; compute cycles per operation

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  unit can accept a request this cycle
op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  computed result
zero  output  1  result == 0; qualified by out_valid
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (reset_n low, async):
  - State goes to IDLE; slice counter = 0; captured operands and op = 0.
  - Outputs: result = 0, zero = 0, out_valid = 0, busy = 0, in_ready = 1 once in IDLE.
- States:
  - IDLE: in_ready = 1.
  - RUN: in_ready = 0.
  - DONE: in_ready = out_ready.
- Accept: a handshake occurs on an edge where in_valid && in_ready.
  - a, b and op are captured; counter = 0; next state RUN.
  - a, b and op are ignored in all other cycles.
  - A change in a, b or op after acceptance has no effect.
- RUN, each cycle:
  - Apply op to captured slice [counter*SLICE +: SLICE] of A and B.
  - Write the SLICE result bits into the same position of the result register.
  - Increment counter.
  - On the edge where counter == NSLICE-1: go to DONE and register out_valid = 1 and zero.
- Latency: accept at edge k, out_valid high after edge k+NSLICE (8 cycles at default parameters).
- Intermediate result bits are not guaranteed while out_valid = 0.
- DONE:
  - out_valid = 1; result and zero held stable until out_valid && out_ready.
  - On out_ready with in_valid = 0: next state IDLE, out_valid = 0. result keeps its last value.
  - On out_ready with in_valid = 1: new request accepted on the same edge, next state RUN (back-to-back, no bubble cycle).
  - On out_ready = 0: in_ready = 0 and new requests stall.
- zero is computed from the final full-width result only, never from partial slices.
- Counter: width clog2(NSLICE), minimum 1 bit. No wrap inside an operation; it is reloaded to 0 on every accept.
- Reset mid-operation (RUN or DONE): the operation is aborted, the pending result is discarded, and no out_valid is issued for it.
- Degenerate case SLICE == WIDTH: NSLICE = 1; one RUN cycle, so latency is 1.

Test Plan:
- NOR, default params: accept a=0x0000FFFF, b=0x00FF00FF, op=11, out_ready=1 -> out_valid exactly 8 cycles after accept, result=0xFF000000, zero=0, in_ready=0 throughout RUN.
- AND with zero flag: a=0xF0F0F0F0, b=0x0F0F0F0F, op=00 -> result=0x00000000, zero=1.
- XOR with backpressure: a=0xFFFFFFFF, b=0x12345678, op=10, out_ready held 0 for 5 cycles after out_valid -> result stays 0xEDCBA987 and out_valid stays 1; a new in_valid is not accepted until out_ready=1.
- Back-to-back: during DONE of an OR 0x80000001|0x00000002, assert out_ready=1 and in_valid with AND 0xFFFF0000&0x0F0F0F0F -> result 0x80000003 consumed; second op accepted on the same edge and yields 0x0F0F0000 8 cycles later.
- Ignored input and reset abort:
  - Change a, b and op during RUN -> result reflects the captured values only.
  - Drop reset_n at RUN cycle 4 -> out_valid=0, result=0, in_ready=1 after release.
  - A following op computes correctly.
- Parameter sweep: SLICE=1 (latency 32) and SLICE=32 (latency 1) with the NOR vector above -> result=0xFF000000 in both.
